cache_coh_ctrl: RTL and testbench

CACHE_COH_CTRL -- requirements
Module: cache_coh_ctrl

---
 rtl/cache_coh_ctrl.sv | 167 ++++++++++++++++
 tb/tb_cache_coh_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/cache_coh_ctrl.sv
// Snooping MSI cache-coherence controller with a direct-mapped tag/state array.
// Handles CPU load/store misses and upgrades over the bus, plus snoop search/invalidate.
module cache_coh_ctrl #(
    parameter int unsigned NSETS       = 16,
    parameter int unsigned FILL_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [10:0] cpu_addr,
    output logic        cpu_stall,
    output logic        read_miss,
    output logic        write_miss,
    output logic        invalidate,
    output logic [10:0] addr_out,
    output logic [1:0]  block_state,
    input  logic        grant,
    input  logic        search,
    input  logic        invalidate_tag,
    input  logic [10:0] snoop_addr,
    output logic        search_found,
    output logic        fill_done
);

    localparam int unsigned IDX_W = $clog2(NSETS);
    localparam int unsigned TAG_W = 11 - IDX_W;
    localparam int unsigned CNT_W = $clog2(FILL_CYCLES + 1);

    typedef enum logic [1:0] {ST_M = 2'b00, ST_S = 2'b01, ST_I = 2'b10} line_st_e;
    typedef enum logic [1:0] {IDLE, REQ, FILL} state_e;
    typedef enum logic [1:0] {OP_RD, OP_WR, OP_INV} op_e;

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic [10:0]        addr_q, addr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               fill_done_q, fill_done_d;
    logic               search_found_q, search_found_d;
    logic               install;

    logic [TAG_W-1:0]   tag_q [NSETS];
    logic [TAG_W-1:0]   tag_d [NSETS];
    line_st_e           st_q  [NSETS];
    line_st_e           st_d  [NSETS];

    logic [IDX_W-1:0]   cpu_idx, miss_idx, snp_idx;
    logic [TAG_W-1:0]   cpu_tag, miss_tag, snp_tag;
    logic               cpu_match, cpu_hit, miss_hit, snp_hit;

    assign cpu_idx  = cpu_addr[IDX_W-1:0];
    assign cpu_tag  = cpu_addr[10:IDX_W];
    assign miss_idx = addr_q[IDX_W-1:0];
    assign miss_tag = addr_q[10:IDX_W];
    assign snp_idx  = snoop_addr[IDX_W-1:0];
    assign snp_tag  = snoop_addr[10:IDX_W];

    assign cpu_match = (tag_q[cpu_idx] == cpu_tag);
    assign cpu_hit   = cpu_match && (st_q[cpu_idx] != ST_I);
    assign miss_hit  = (tag_q[miss_idx] == miss_tag) && (st_q[miss_idx] != ST_I);
    assign snp_hit   = (tag_q[snp_idx] == snp_tag) && (st_q[snp_idx] != ST_I);

    assign block_state  = cpu_match ? st_q[cpu_idx] : ST_I;
    assign addr_out     = addr_q;
    assign fill_done    = fill_done_q;
    assign search_found = search_found_q;

    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        addr_d         = addr_q;
        cnt_d          = cnt_q;
        install        = 1'b0;
        cpu_stall      = 1'b0;
        read_miss      = 1'b0;
        write_miss     = 1'b0;
        invalidate     = 1'b0;
        search_found_d = search && snp_hit;

        case (state_q)
            IDLE: begin
                if (cpu_rd && !cpu_hit) begin
                    addr_d    = cpu_addr;
                    op_d      = OP_RD;
                    state_d   = REQ;
                    cpu_stall = 1'b1;
                end else if (cpu_wr && !cpu_hit) begin
                    addr_d    = cpu_addr;
                    op_d      = OP_WR;
                    state_d   = REQ;
                    cpu_stall = 1'b1;
                end else if (cpu_wr && st_q[cpu_idx] == ST_S) begin
                    addr_d    = cpu_addr;
                    op_d      = OP_INV;
                    state_d   = REQ;
                    cpu_stall = 1'b1;
                end
            end
            REQ: begin
                cpu_stall = 1'b1;
                // A pending upgrade whose line was snooped away turns into a full write miss.
                if (op_q == OP_INV && !miss_hit)
                    op_d = OP_WR;
                read_miss  = (op_d == OP_RD);
                write_miss = (op_d == OP_WR);
                invalidate = (op_d == OP_INV);
                if (grant) begin
                    state_d = FILL;
                    cnt_d   = '0;
                end
            end
            FILL: begin
                cpu_stall = 1'b1;
                if (op_q != OP_RD || cnt_q == CNT_W'(FILL_CYCLES - 1)) begin
                    install = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q != CNT_W'(FILL_CYCLES)) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        fill_done_d = install;
    end

    // Snoop updates first, own install last so it takes priority on a shared set.
    always_comb begin
        st_d  = st_q;
        tag_d = tag_q;
        if (search && snp_hit && st_q[snp_idx] == ST_M)
            st_d[snp_idx] = ST_S;
        if (invalidate_tag && snp_hit)
            st_d[snp_idx] = ST_I;
        if (install) begin
            tag_d[miss_idx] = miss_tag;
            st_d[miss_idx]  = (op_q == OP_RD) ? ST_S : ST_M;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            op_q           <= OP_RD;
            addr_q         <= '0;
            cnt_q          <= '0;
            fill_done_q    <= 1'b0;
            search_found_q <= 1'b0;
            for (int unsigned i = 0; i < NSETS; i++) begin
                tag_q[i] <= '0;
                st_q[i]  <= ST_I;
            end
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            addr_q         <= addr_d;
            cnt_q          <= cnt_d;
            fill_done_q    <= fill_done_d;
            search_found_q <= search_found_d;
            for (int unsigned i = 0; i < NSETS; i++) begin
                tag_q[i] <= tag_d[i];
                st_q[i]  <= st_d[i];
            end
        end
    end

endmodule

// File: tb/tb_cache_coh_ctrl.sv
// Directed bench for cache_coh_ctrl: expected outputs are queued per step and
// drained against the DUT after the outputs settle.
module tb_cache_coh_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_rd, cpu_wr, grant, search, invalidate_tag;
    logic [10:0] cpu_addr, snoop_addr;
    logic        cpu_stall, read_miss, write_miss, invalidate;
    logic        search_found, fill_done;
    logic [10:0] addr_out;
    logic [1:0]  block_state;

    int checks = 0;
    int errors = 0;

    typedef enum {F_STALL, F_RM, F_WM, F_INV, F_ADDR, F_BS, F_SF, F_FD} fld_e;
    typedef struct {
        string       tag;
        fld_e        f;
        logic [10:0] v;
    } exp_t;
    exp_t sb[$];

    cache_coh_ctrl #(.NSETS(16), .FILL_CYCLES(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cpu_rd         (cpu_rd),
        .cpu_wr         (cpu_wr),
        .cpu_addr       (cpu_addr),
        .cpu_stall      (cpu_stall),
        .read_miss      (read_miss),
        .write_miss     (write_miss),
        .invalidate     (invalidate),
        .addr_out       (addr_out),
        .block_state    (block_state),
        .grant          (grant),
        .search         (search),
        .invalidate_tag (invalidate_tag),
        .snoop_addr     (snoop_addr),
        .search_found   (search_found),
        .fill_done      (fill_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic push(input string tag, input fld_e f, input logic [10:0] v);
        exp_t e;
        e.tag = tag;
        e.f   = f;
        e.v   = v;
        sb.push_back(e);
    endtask

    function automatic logic [10:0] observe(input fld_e f);
        case (f)
            F_STALL: return {10'd0, cpu_stall};
            F_RM:    return {10'd0, read_miss};
            F_WM:    return {10'd0, write_miss};
            F_INV:   return {10'd0, invalidate};
            F_ADDR:  return addr_out;
            F_BS:    return {9'd0, block_state};
            F_SF:    return {10'd0, search_found};
            default: return {10'd0, fill_done};
        endcase
    endfunction

    task automatic drain();
        exp_t        e;
        logic [10:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.f);
            checks++;
            assert (obs === e.v) else begin
                errors++;
                $error("FAIL %s: observed 0x%0h expected 0x%0h", e.tag, obs, e.v);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0; grant = 1'b0;
        search = 1'b0; invalidate_tag = 1'b0;
        cpu_addr = 11'h123; snoop_addr = 11'h000;
        #12;
        push("rst_stall", F_STALL, 0); push("rst_rm", F_RM, 0); push("rst_wm", F_WM, 0);
        push("rst_inv", F_INV, 0); push("rst_addr", F_ADDR, 0); push("rst_bs", F_BS, 2);
        push("rst_sf", F_SF, 0); push("rst_fd", F_FD, 0);
        drain();
        rst_n = 1'b1;
        tick();

        // Read miss on 0x123, two FILL cycles, installed Shared
        cpu_rd = 1'b1; settle();
        push("rd_idle_stall", F_STALL, 1); push("rd_idle_rm", F_RM, 0); push("rd_idle_bs", F_BS, 2);
        drain();
        tick();
        push("rd_req_rm", F_RM, 1); push("rd_req_addr", F_ADDR, 11'h123); push("rd_req_stall", F_STALL, 1);
        push("rd_req_wm", F_WM, 0); push("rd_req_inv", F_INV, 0);
        drain();
        tick();
        push("rd_req_held", F_RM, 1); drain();
        grant = 1'b1; settle();
        push("rd_grant_rm", F_RM, 1); drain();
        tick(); grant = 1'b0; settle();
        push("rd_fill1_rm", F_RM, 0); push("rd_fill1_stall", F_STALL, 1); push("rd_fill1_fd", F_FD, 0);
        drain();
        tick();
        push("rd_fill2_stall", F_STALL, 1); push("rd_fill2_fd", F_FD, 0); drain();
        tick();
        push("rd_done_fd", F_FD, 1); push("rd_done_bs", F_BS, 1); push("rd_done_stall", F_STALL, 0);
        drain();
        cpu_rd = 1'b0; tick();
        push("rd_fd_pulse", F_FD, 0); drain();

        // Write hit in Shared: upgrade, one FILL cycle, Modified
        cpu_wr = 1'b1; settle();
        push("up_idle_stall", F_STALL, 1); push("up_idle_bs", F_BS, 1); drain();
        tick();
        push("up_req_inv", F_INV, 1); push("up_req_wm", F_WM, 0); push("up_req_rm", F_RM, 0); drain();
        grant = 1'b1; tick(); grant = 1'b0; settle();
        push("up_fill_inv", F_INV, 0); push("up_fill_stall", F_STALL, 1); push("up_fill_fd", F_FD, 0);
        drain();
        tick();
        push("up_done_fd", F_FD, 1); push("up_done_bs", F_BS, 0); push("up_done_stall", F_STALL, 0);
        drain();
        cpu_wr = 1'b0; tick();

        // Snoop search: Modified hit downgrades, other tag misses
        search = 1'b1; snoop_addr = 11'h123; tick();
        push("srch_hit_sf", F_SF, 1); push("srch_hit_bs", F_BS, 1); drain();
        snoop_addr = 11'h223; tick();
        push("srch_miss_sf", F_SF, 0); drain();
        snoop_addr = 11'h123; tick();
        push("srch_shared_sf", F_SF, 1); drain();
        search = 1'b0; tick();
        push("srch_idle_sf", F_SF, 0); push("srch_keep_bs", F_BS, 1); drain();

        // Pending upgrade snooped away becomes a write miss
        cpu_wr = 1'b1; tick();
        invalidate_tag = 1'b1; snoop_addr = 11'h123; settle();
        push("snpinv_pre_inv", F_INV, 1); drain();
        tick(); invalidate_tag = 1'b0; settle();
        push("snpinv_inv", F_INV, 0); push("snpinv_wm", F_WM, 1); push("snpinv_bs", F_BS, 2); drain();
        grant = 1'b1; tick(); grant = 1'b0; settle();
        push("snpinv_fill_wm", F_WM, 0); push("snpinv_fill_stall", F_STALL, 1); drain();
        tick();
        push("snpinv_done_fd", F_FD, 1); push("snpinv_done_bs", F_BS, 0); push("snpinv_done_stall", F_STALL, 0);
        drain();
        cpu_wr = 1'b0; tick();

        // Write miss installs 0x1A5 Modified
        cpu_wr = 1'b1; cpu_addr = 11'h1A5; tick();
        push("wm_req_wm", F_WM, 1); push("wm_req_addr", F_ADDR, 11'h1A5); drain();
        grant = 1'b1; tick(); grant = 1'b0; tick();
        push("wm_done_fd", F_FD, 1); push("wm_done_bs", F_BS, 0); drain();
        cpu_wr = 1'b0;

        // Read miss to 0x0A5 (same set) while snoop invalidates 0x1A5 on the install edge
        cpu_rd = 1'b1; cpu_addr = 11'h0A5; settle();
        push("prio_idle_bs", F_BS, 2); push("prio_idle_stall", F_STALL, 1); drain();
        tick(); grant = 1'b1; tick(); grant = 1'b0; tick();
        invalidate_tag = 1'b1; snoop_addr = 11'h1A5; tick(); invalidate_tag = 1'b0; settle();
        push("prio_fd", F_FD, 1); push("prio_bs", F_BS, 1); push("prio_stall", F_STALL, 0); drain();
        cpu_rd = 1'b0; cpu_addr = 11'h1A5; settle();
        push("prio_old_bs", F_BS, 2); drain();

        // Reset while in FILL aborts the miss
        cpu_rd = 1'b1; cpu_addr = 11'h456; tick();
        grant = 1'b1; tick(); grant = 1'b0; settle();
        push("rstf_fill_stall", F_STALL, 1); push("rstf_fill_addr", F_ADDR, 11'h456); drain();
        rst_n = 1'b0; #1;
        push("rstf_rm", F_RM, 0); push("rstf_addr", F_ADDR, 0); push("rstf_fd", F_FD, 0);
        push("rstf_bs", F_BS, 2); push("rstf_stall", F_STALL, 1); drain();
        cpu_addr = 11'h123; #1;
        push("rstf_other_bs", F_BS, 2); drain();
        cpu_addr = 11'h456; cpu_rd = 1'b0;
        tick(); rst_n = 1'b1; tick(); tick();
        push("rstf_after_fd", F_FD, 0); push("rstf_after_bs", F_BS, 2); drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
